// File: rtl/forward_hazard_unit.sv
// rtl/forward_hazard_unit.sv - operand forwarding selects and load-use stall control
module forward_hazard_unit #(
    parameter int REG_W      = 5,
    parameter int LOAD_STALL = 1,
    parameter int WB_BYPASS  = 1,
    parameter int PERF_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic              id_uses_rt,
    input  logic [REG_W-1:0]  ex_rs,
    input  logic [REG_W-1:0]  ex_rt,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic [REG_W-1:0]  mem_rd,
    input  logic              mem_regwrite,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic              wb_regwrite,
    input  logic              flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              stall,
    output logic              bubble,
    output logic [PERF_W-1:0] stall_cycles,
    output logic              busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam logic [3:0] RELOAD = 4'(LOAD_STALL - 1);
    localparam logic       BYPASS_EN = (WB_BYPASS != 0);

    state_t           state, state_nxt;
    logic [3:0]       cnt, cnt_nxt;
    logic [REG_W-1:0] ret_rd;
    logic             ret_we;
    logic             hazard;
    logic             stall_raw;

    // Strict priority: youngest producer wins; register 0 is hardwired and never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_W-1:0] src,
        input logic [REG_W-1:0] m_rd,
        input logic             m_we,
        input logic [REG_W-1:0] w_rd,
        input logic             w_we,
        input logic [REG_W-1:0] r_rd,
        input logic             r_we
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (src != '0) begin
            if (m_we && (m_rd == src))
                sel = 2'b10;
            else if (w_we && (w_rd == src))
                sel = 2'b01;
            else if (BYPASS_EN && r_we && (r_rd == src))
                sel = 2'b11;
        end
        return sel;
    endfunction

    always_comb begin
        fwd_a = fwd_sel(ex_rs, mem_rd, mem_regwrite, wb_rd, wb_regwrite, ret_rd, ret_we);
        fwd_b = fwd_sel(ex_rt, mem_rd, mem_regwrite, wb_rd, wb_regwrite, ret_rd, ret_we);
    end

    always_comb begin
        hazard = id_valid && ex_memread && ex_regwrite && (ex_rd != '0) &&
                 ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall_raw = 1'b0;
        case (state)
            IDLE: begin
                if (hazard) begin
                    stall_raw = 1'b1;
                    if (LOAD_STALL > 1) begin
                        state_nxt = STALL;
                        cnt_nxt   = RELOAD;
                    end
                end
            end
            STALL: begin
                // New hazards are not evaluated here, so cnt is never reloaded mid-stall.
                stall_raw = 1'b1;
                cnt_nxt   = cnt - 4'd1;
                if (cnt == 4'd1)
                    state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
        if (flush) begin
            stall_raw = 1'b0;
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
        end
    end

    assign stall  = stall_raw & rst_n;
    assign bubble = stall_raw & rst_n;
    assign busy   = (state == STALL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            ret_rd <= '0;
            ret_we <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            ret_rd <= wb_rd;
            ret_we <= wb_regwrite;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cycles <= '0;
        else if (stall && (stall_cycles != '1))
            stall_cycles <= stall_cycles + PERF_W'(1);
    end

endmodule

// File: tb/tb_forward_hazard_unit.sv
// tb/tb_forward_hazard_unit.sv - directed vector bench for forward_hazard_unit
module tb_forward_hazard_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_uses_rt, ex_regwrite, ex_memread;
    logic       mem_regwrite, wb_regwrite, flush;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;

    logic [1:0]  d_fa, d_fb, s_fa, s_fb, n_fa, n_fb;
    logic        d_stall, d_bubble, d_busy;
    logic        s_stall, s_bubble, s_busy;
    logic        n_stall, n_bubble, n_busy;
    logic [15:0] d_sc, s_sc;
    logic [3:0]  n_sc;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    forward_hazard_unit u_def (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .mem_rd(mem_rd),
        .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .flush(flush), .fwd_a(d_fa), .fwd_b(d_fb), .stall(d_stall), .bubble(d_bubble),
        .stall_cycles(d_sc), .busy(d_busy)
    );

    forward_hazard_unit #(.LOAD_STALL(3)) u_ls3 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .mem_rd(mem_rd),
        .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .flush(flush), .fwd_a(s_fa), .fwd_b(s_fb), .stall(s_stall), .bubble(s_bubble),
        .stall_cycles(s_sc), .busy(s_busy)
    );

    forward_hazard_unit #(.LOAD_STALL(3), .WB_BYPASS(0), .PERF_W(4)) u_nb (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .mem_rd(mem_rd),
        .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .flush(flush), .fwd_a(n_fa), .fwd_b(n_fb), .stall(n_stall), .bubble(n_bubble),
        .stall_cycles(n_sc), .busy(n_busy)
    );

    typedef struct {
        string      name;
        logic [4:0] rs, rt, m_rd, w_rd, r_rd;
        logic       m_we, w_we, r_we;
        logic [1:0] exp_a, exp_b;       // with retired bypass enabled
        logic [1:0] exp_a_nb, exp_b_nb; // with retired bypass disabled
    } fwd_vec_t;

    fwd_vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_hazard(input logic on);
        id_valid    = on;
        ex_memread  = on;
        ex_regwrite = on;
        ex_rd       = 5'd5;
        id_rs       = 5'd5;
        id_rt       = 5'd9;
        id_uses_rt  = 1'b0;
    endtask

    initial begin
        vecs[0] = '{"ex_mem_over_wb",   5'd3,  5'd4,  5'd3,  5'd3,  5'd0,  1'b1, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00};
        vecs[1] = '{"zero_never_fwd",   5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00};
        vecs[2] = '{"retired_rs",       5'd7,  5'd2,  5'd1,  5'd2,  5'd7,  1'b1, 1'b1, 1'b1, 2'b11, 2'b01, 2'b00, 2'b01};
        vecs[3] = '{"mem_we_off",       5'd6,  5'd6,  5'd6,  5'd6,  5'd0,  1'b0, 1'b1, 1'b0, 2'b01, 2'b01, 2'b01, 2'b01};
        vecs[4] = '{"wb_over_retired",  5'd9,  5'd9,  5'd0,  5'd9,  5'd9,  1'b0, 1'b1, 1'b1, 2'b01, 2'b01, 2'b01, 2'b01};
        vecs[5] = '{"retired_we_off",   5'd9,  5'd8,  5'd1,  5'd2,  5'd9,  1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00};
        vecs[6] = '{"split_wb_mem",     5'd12, 5'd31, 5'd31, 5'd12, 5'd12, 1'b1, 1'b1, 1'b1, 2'b01, 2'b10, 2'b01, 2'b10};
        vecs[7] = '{"retired_rt",       5'd1,  5'd20, 5'd1,  5'd3,  5'd20, 1'b1, 1'b0, 1'b1, 2'b10, 2'b11, 2'b10, 2'b00};

        rst_n = 1'b0;
        flush = 1'b0;
        ex_rs = '0; ex_rt = '0; mem_rd = '0; wb_rd = '0;
        mem_regwrite = 1'b0; wb_regwrite = 1'b0;
        set_hazard(1'b1);
        #1;
        check("reset_stall_masked", {31'd0, s_stall}, 32'd0);
        check("reset_bubble_masked", {31'd0, s_bubble}, 32'd0);
        check("reset_busy", {31'd0, s_busy}, 32'd0);
        check("reset_stall_cycles", {16'd0, s_sc}, 32'd0);
        set_hazard(1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Forwarding table: preload the retired register through one WB cycle, then probe.
        foreach (vecs[i]) begin
            mem_regwrite = 1'b0;
            wb_rd        = vecs[i].r_rd;
            wb_regwrite  = vecs[i].r_we;
            tick();
            ex_rs        = vecs[i].rs;
            ex_rt        = vecs[i].rt;
            mem_rd       = vecs[i].m_rd;
            mem_regwrite = vecs[i].m_we;
            wb_rd        = vecs[i].w_rd;
            wb_regwrite  = vecs[i].w_we;
            #1;
            check({vecs[i].name, "/fwd_a"},    {30'd0, d_fa}, {30'd0, vecs[i].exp_a});
            check({vecs[i].name, "/fwd_b"},    {30'd0, d_fb}, {30'd0, vecs[i].exp_b});
            check({vecs[i].name, "/fwd_a_nb"}, {30'd0, n_fa}, {30'd0, vecs[i].exp_a_nb});
            check({vecs[i].name, "/fwd_b_nb"}, {30'd0, n_fb}, {30'd0, vecs[i].exp_b_nb});
        end
        mem_regwrite = 1'b0;
        wb_regwrite  = 1'b0;
        tick();

        // Three-cycle load-use stall.
        rst_n = 1'b0; #1; rst_n = 1'b1;
        set_hazard(1'b1);
        #1;
        check("ls3_c1_stall", {31'd0, s_stall}, 32'd1);
        check("ls3_c1_bubble", {31'd0, s_bubble}, 32'd1);
        check("ls3_c1_busy", {31'd0, s_busy}, 32'd0);
        tick();
        set_hazard(1'b0);
        #1;
        check("ls3_c2_stall", {31'd0, s_stall}, 32'd1);
        check("ls3_c2_busy", {31'd0, s_busy}, 32'd1);
        tick();
        check("ls3_c3_stall", {31'd0, s_stall}, 32'd1);
        check("ls3_c3_busy", {31'd0, s_busy}, 32'd1);
        tick();
        check("ls3_done_stall", {31'd0, s_stall}, 32'd0);
        check("ls3_done_busy", {31'd0, s_busy}, 32'd0);
        check("ls3_stall_cycles", {16'd0, s_sc}, 32'd3);

        // Flush on the second stall cycle.
        rst_n = 1'b0; #1; rst_n = 1'b1;
        set_hazard(1'b1);
        #1;
        check("flush_c1_stall", {31'd0, s_stall}, 32'd1);
        tick();
        set_hazard(1'b0);
        flush = 1'b1;
        #1;
        check("flush_c2_stall", {31'd0, s_stall}, 32'd0);
        check("flush_c2_bubble", {31'd0, s_bubble}, 32'd0);
        tick();
        flush = 1'b0;
        #1;
        check("flush_idle_busy", {31'd0, s_busy}, 32'd0);
        check("flush_idle_stall", {31'd0, s_stall}, 32'd0);
        check("flush_stall_cycles", {16'd0, s_sc}, 32'd1);

        // Flush while idle masks a fresh hazard.
        set_hazard(1'b1);
        flush = 1'b1;
        #1;
        check("flush_idle_mask", {31'd0, s_stall}, 32'd0);
        tick();
        check("flush_idle_no_count", {16'd0, s_sc}, 32'd1);
        check("flush_idle_no_enter", {31'd0, s_busy}, 32'd0);
        flush = 1'b0;
        set_hazard(1'b0);

        // Held hazard: 20 back-to-back stall cycles, saturation, then reset mid-STALL.
        rst_n = 1'b0; #1; rst_n = 1'b1;
        set_hazard(1'b1);
        #1;
        check("sat_first_stall", {31'd0, n_stall}, 32'd1);
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 3) begin
                check("sat_no_reload_busy", {31'd0, n_busy}, 32'd0);
                check("sat_restall", {31'd0, n_stall}, 32'd1);
            end
        end
        check("sat_mid_stall_busy", {31'd0, n_busy}, 32'd1);
        check("sat_stall_cycles", {28'd0, n_sc}, 32'd15);
        check("wide_stall_cycles", {16'd0, s_sc}, 32'd20);
        check("def_stall_cycles", {16'd0, d_sc}, 32'd20);
        rst_n = 1'b0;
        #1;
        check("rst_mid_stall_sc", {28'd0, n_sc}, 32'd0);
        check("rst_mid_stall_busy", {31'd0, n_busy}, 32'd0);
        check("rst_mid_stall_stall", {31'd0, n_stall}, 32'd0);
        set_hazard(1'b0);
        rst_n = 1'b1;
        tick();
        check("post_rst_busy", {31'd0, n_busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
